bin2bcd_seq_ctrl: RTL and testbench

Sequential controller for signed binary-to-BCD conversion using the iterative shift-and-add-3 (double-dabble) algorithm.
- Replaces the unrolled adder tree with a single add-3 stage per digit, reused every cycle and sequenced by an FSM with a start/busy/done handshake.
- Sits between the switch/input logic and the BCD-to-7-segment decoders.
- Registered H/T/U digits and sign are held stable between conversions.

---
 rtl/bin2bcd_seq_ctrl.sv | 115 +++++++++++
 tb/tb_bin2bcd_seq_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential signed binary-to-BCD converter (double-dabble), one shift per enabled cycle.
// A start/busy/done handshake sequences the conversion; H/T/U/sign stay registered between results.
module bin2bcd_seq_ctrl #(
  parameter int WORD_LENGTH = 8,
  parameter int CNT_W       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] bin,
  output logic                   busy,
  output logic                   done,
  output logic [3:0]             H,
  output logic [3:0]             T,
  output logic [3:0]             U,
  output logic                   sign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT                  state;
  stateT                  stateNext;
  logic [CNT_W-1:0]       shiftCnt;
  logic [WORD_LENGTH-1:0] magReg;
  logic [WORD_LENGTH-1:0] magLoad;
  logic [WORD_LENGTH-1:0] magShift;
  logic [3:0]             digH, digT, digU;
  logic [3:0]             adjH, adjT, adjU;
  logic [3:0]             nextH, nextT, nextU;
  logic                   signReg;
  logic                   lastShift;
  logic                   accept;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Negating in W bits gives 2^(W-1) as an unsigned W-bit value, so the most negative input is exact.
  assign magLoad   = bin[WORD_LENGTH-1] ? (~bin) + WORD_LENGTH'(1) : bin;
  assign lastShift = (shiftCnt == CNT_W'(WORD_LENGTH - 1));
  assign accept    = enable && start && (state != CONV);

  // All digits are corrected from their pre-shift values, then the whole chain shifts as one.
  assign adjH = add3(digH);
  assign adjT = add3(digT);
  assign adjU = add3(digU);
  assign {nextH, nextT, nextU, magShift} = {adjH, adjT, adjU, magReg} << 1;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    // NOTE: assigning a default before the case keeps this combinational block free of latches.
    stateNext = state;
    if (enable) begin
      case (state)
        IDLE:    if (start) stateNext = CONV;
        CONV:    if (lastShift) stateNext = DONE;
        DONE:    stateNext = start ? CONV : IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == CONV);
    done = (state == DONE) && enable;
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      shiftCnt <= '0;
      magReg   <= '0;
      digH     <= '0;
      digT     <= '0;
      digU     <= '0;
      signReg  <= 1'b1;
      H        <= '0;
      T        <= '0;
      U        <= '0;
      sign     <= 1'b1;
    end else if (enable) begin
      if (accept) begin
        signReg  <= ~bin[WORD_LENGTH-1];
        magReg   <= magLoad;
        digH     <= '0;
        digT     <= '0;
        digU     <= '0;
        shiftCnt <= '0;
      end else if (state == CONV) begin
        digH     <= nextH;
        digT     <= nextT;
        digU     <= nextU;
        magReg   <= magShift;
        shiftCnt <= shiftCnt + CNT_W'(1);
        // Results are published on the final shift so they are valid throughout the done cycle.
        if (lastShift) begin
          H    <= nextH;
          T    <= nextT;
          U    <= nextU;
          sign <= signReg;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// Self-checking bench for bin2bcd_seq_ctrl: directed handshake scenarios plus randomized
// operands and enable gaps, checked against a decimal-arithmetic reference model.
module tb_bin2bcd_seq_ctrl;
  localparam int W  = 8;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         start;
  logic [W-1:0] bin;
  logic         busy;
  logic         done;
  logic [3:0]   H, T, U;
  logic         sign;

  int checks = 0;
  int fails  = 0;

  bin2bcd_seq_ctrl #(.WORD_LENGTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .bin(bin),
    .busy(busy), .done(done), .H(H), .T(T), .U(U), .sign(sign)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Reference result {sign, H, T, U} from plain decimal arithmetic.
  function automatic logic [12:0] refBcd(input logic [W-1:0] b);
    int v, m;
    v = int'($signed(b));
    m = (v < 0) ? -v : v;
    return {(v >= 0) ? 1'b1 : 1'b0, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One conversion with random enable gaps and random start noise while converting.
  // Expected timing: W enabled cycles in CONV, then done on the next enabled cycle.
  task automatic runConv(input logic [W-1:0] b, input int offPct,
                         output int doneCyc, output int expCyc,
                         output int busyCnt, output int expBusy, output logic [12:0] res);
    int enCnt;
    enCnt = 0; doneCyc = -1; expCyc = -1; busyCnt = 0; expBusy = 0; res = '0;
    enable = 1'b1; start = 1'b1; bin = b;
    nextCycle();
    for (int c = 1; c <= 100 && doneCyc < 0; c++) begin
      enable = ($urandom_range(99) < offPct) ? 1'b0 : 1'b1;
      bin    = W'($urandom);
      start  = (enCnt < W) ? 1'($urandom_range(1)) : 1'b0;
      if (enCnt < W) expBusy++;
      if (enable && enCnt == W && expCyc < 0) expCyc = c;
      @(negedge clk);
      if (busy) busyCnt++;
      if (done) begin
        doneCyc = c;
        res = {sign, H, T, U};
      end
      if (enable) enCnt++;
      nextCycle();
    end
    start  = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; start = 1'b1; bin = W'($urandom);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checks++;
    if ({busy, done, sign, H, T, U} !== {1'b0, 1'b0, 1'b1, 12'h000}) begin
      fails++;
      $display("FAIL reset_state: got busy=%b done=%b sign=%b HTU=%h, expected 0 0 1 000",
               busy, done, sign, {H, T, U});
    end
    reset = 1'b0; enable = 1'b1; start = 1'b0;
    nextCycle();
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      fails++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, expected 0 0", busy, done);
    end
    nextCycle();
  endtask

  task automatic test_directed();
    logic [W-1:0] vals [5] = '{8'd0, 8'd127, 8'hFF, 8'h80, 8'd1};
    int dc, ec, bc, eb;
    logic [12:0] res;
    foreach (vals[i]) begin
      runConv(vals[i], 0, dc, ec, bc, eb, res);
      checks++;
      if (res !== refBcd(vals[i])) begin
        fails++;
        $display("FAIL directed_result bin=%h: got %h, expected %h", vals[i], res, refBcd(vals[i]));
      end
      checks++;
      if (dc != W + 1 || ec != W + 1) begin
        fails++;
        $display("FAIL directed_latency bin=%h: got %0d, expected %0d", vals[i], dc, W + 1);
      end
      checks++;
      if (bc != W) begin
        fails++;
        $display("FAIL directed_busy_cycles bin=%h: got %0d, expected %0d", vals[i], bc, W);
      end
      @(negedge clk);
      checks++;
      if ({done, busy, sign, H, T, U} !== {2'b00, refBcd(vals[i])}) begin
        fails++;
        $display("FAIL directed_after_done bin=%h: got done=%b busy=%b out=%h, expected 0 0 %h",
                 vals[i], done, busy, {sign, H, T, U}, refBcd(vals[i]));
      end
      nextCycle();
    end
  endtask

  task automatic test_random();
    int dc, ec, bc, eb;
    logic [12:0] res;
    logic [W-1:0] b;
    for (int i = 0; i < 25; i++) begin
      b = W'($urandom);
      runConv(b, 25, dc, ec, bc, eb, res);
      checks++;
      if (res !== refBcd(b)) begin
        fails++;
        $display("FAIL random_result bin=%h: got %h, expected %h", b, res, refBcd(b));
      end
      checks++;
      if (dc != ec) begin
        fails++;
        $display("FAIL random_latency bin=%h: got cycle %0d, expected %0d", b, dc, ec);
      end
      checks++;
      if (bc != eb) begin
        fails++;
        $display("FAIL random_busy_cycles bin=%h: got %0d, expected %0d", b, bc, eb);
      end
    end
  endtask

  task automatic test_ignore_start();
    int nDone = 0, dCyc = -1;
    logic [12:0] res = '0;
    enable = 1'b1; start = 1'b1; bin = 8'd99;
    nextCycle();
    for (int c = 1; c <= 20; c++) begin
      start = (c >= 3 && c <= 6);
      bin   = start ? 8'd5 : W'($urandom);
      @(negedge clk);
      if (done) begin
        nDone++;
        if (dCyc < 0) begin
          dCyc = c;
          res = {sign, H, T, U};
        end
      end
      nextCycle();
    end
    start = 1'b0;
    checks++;
    if (nDone != 1) begin
      fails++;
      $display("FAIL ignore_done_count: got %0d, expected 1", nDone);
    end
    checks++;
    if (dCyc != W + 1) begin
      fails++;
      $display("FAIL ignore_latency: got %0d, expected %0d", dCyc, W + 1);
    end
    checks++;
    if (res !== refBcd(8'd99)) begin
      fails++;
      $display("FAIL ignore_result: got %h, expected %h", res, refBcd(8'd99));
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int cyc [2] = '{-1, -1};
    logic [12:0] res [2] = '{13'h0, 13'h0};
    bit holdBad = 1'b0;
    enable = 1'b1; start = 1'b1; bin = 8'd42;
    nextCycle();
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) begin
        if (n < 2) begin
          cyc[n] = c;
          res[n] = {sign, H, T, U};
        end
        n++;
        if (n == 1) bin = 8'd100;
        if (n == 2) start = 1'b0;
      end else if (n == 1 && {sign, H, T, U} !== refBcd(8'd42)) begin
        holdBad = 1'b1;
      end
      nextCycle();
    end
    start = 1'b0;
    checks++;
    if (n != 2) begin
      fails++;
      $display("FAIL b2b_done_count: got %0d, expected 2", n);
    end
    checks++;
    if (cyc[0] != W + 1 || cyc[1] != 2 * (W + 1)) begin
      fails++;
      $display("FAIL b2b_timing: got %0d,%0d, expected %0d,%0d", cyc[0], cyc[1], W + 1, 2 * (W + 1));
    end
    checks++;
    if (res[0] !== refBcd(8'd42)) begin
      fails++;
      $display("FAIL b2b_first_result: got %h, expected %h", res[0], refBcd(8'd42));
    end
    checks++;
    if (res[1] !== refBcd(8'd100)) begin
      fails++;
      $display("FAIL b2b_second_result: got %h, expected %h", res[1], refBcd(8'd100));
    end
    checks++;
    if (holdBad !== 1'b0) begin
      fails++;
      $display("FAIL b2b_hold: got outputs changing during second conversion, expected %h held",
               refBcd(8'd42));
    end
  endtask

  task automatic test_reset_abort();
    int nDone = 0;
    enable = 1'b1; start = 1'b1; bin = 8'd200;
    nextCycle();
    start = 1'b0;
    nextCycle();
    nextCycle();
    nextCycle();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, sign, H, T, U} !== {1'b0, 1'b0, 1'b1, 12'h000}) begin
      fails++;
      $display("FAIL abort_state: got busy=%b done=%b sign=%b HTU=%h, expected 0 0 1 000",
               busy, done, sign, {H, T, U});
    end
    nextCycle();
    for (int c = 0; c < 20; c++) begin
      bin = W'($urandom);
      @(negedge clk);
      if (done) nDone++;
      nextCycle();
    end
    checks++;
    if (nDone != 0) begin
      fails++;
      $display("FAIL abort_no_done: got %0d done pulses, expected 0", nDone);
    end
  endtask

  task automatic test_enable_stall();
    int dCyc = -1;
    logic [12:0] res = '0;
    logic [13:0] snap = '0;
    bit frozenBad = 1'b0;
    enable = 1'b1; start = 1'b1; bin = 8'd63;
    nextCycle();
    start = 1'b0;
    for (int c = 1; c <= 30 && dCyc < 0; c++) begin
      enable = !(c >= 4 && c <= 6);
      @(negedge clk);
      if (c == 3) snap = {busy, sign, H, T, U};
      if (!enable && ({busy, sign, H, T, U} !== snap || done !== 1'b0)) frozenBad = 1'b1;
      if (done) begin
        dCyc = c;
        res = {sign, H, T, U};
      end
      nextCycle();
    end
    enable = 1'b1;
    checks++;
    if (dCyc != W + 4) begin
      fails++;
      $display("FAIL stall_latency: got %0d, expected %0d", dCyc, W + 4);
    end
    checks++;
    if (res !== refBcd(8'd63)) begin
      fails++;
      $display("FAIL stall_result: got %h, expected %h", res, refBcd(8'd63));
    end
    checks++;
    if (frozenBad !== 1'b0) begin
      fails++;
      $display("FAIL stall_frozen: got activity while enable=0, expected frozen outputs");
    end

    dCyc = -1;
    start = 1'b1; bin = 8'hDB;
    nextCycle();
    start = 1'b0;
    for (int c = 1; c <= 30 && dCyc < 0; c++) begin
      enable = !(c == W + 1 || c == W + 2);
      @(negedge clk);
      if (done) begin
        dCyc = c;
        res = {sign, H, T, U};
      end
      nextCycle();
    end
    enable = 1'b1;
    checks++;
    if (dCyc != W + 3) begin
      fails++;
      $display("FAIL done_gated_latency: got %0d, expected %0d", dCyc, W + 3);
    end
    checks++;
    if (res !== refBcd(8'hDB)) begin
      fails++;
      $display("FAIL done_gated_result: got %h, expected %h", res, refBcd(8'hDB));
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      fails++;
      $display("FAIL done_gated_idle: got busy=%b done=%b, expected 0 0", busy, done);
    end
    nextCycle();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; start = 1'b0; bin = '0;
    #2;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_enable_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
